// File: rtl/pifo_pkg.sv
// Shared PIFO definitions: sizing helper, comparator tie-break rules and the
// entry record layout used by every PIFO block.
package pifo_pkg;

   function automatic int clog2(input int n);
      int r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Equal ranks: the min search keeps the oldest slot, the max search the newest.
   localparam bit MIN_TIE_OLDEST = 1'b1;
   localparam bit MAX_TIE_NEWEST = 1'b1;

   localparam int PIFO_RANK_WIDTH = 16;
   localparam int PIFO_META_WIDTH = 32;

   typedef struct packed {
      logic                       valid;
      logic [PIFO_RANK_WIDTH-1:0] rank;
      logic [PIFO_META_WIDTH-1:0] meta;
   } pifo_entry_t;

endpackage

// File: rtl/pifo_sel_tree.sv
// Padded binary comparator tree over the PIFO slots; finds the head (min rank,
// oldest on ties) and the eviction victim (max rank, newest on ties).
module pifo_sel_tree
   import pifo_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int RANK_WIDTH = 16,
   parameter int IDX_W      = clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]                 valid_i,
   input  logic [DEPTH-1:0][RANK_WIDTH-1:0] rank_i,
   output logic [IDX_W-1:0]                 min_idx_o,
   output logic [IDX_W-1:0]                 max_idx_o
);

   localparam int LEVELS = clog2(DEPTH);
   localparam int LEAVES = 1 << LEVELS;
   localparam int NODES  = 2 * LEAVES - 1;

   typedef struct packed {
      logic                  valid;
      logic [RANK_WIDTH-1:0] rank;
      logic [IDX_W-1:0]      idx;
   } node_t;

   typedef struct packed {
      logic [IDX_W-1:0] min_idx;
      logic [IDX_W-1:0] max_idx;
   } sel_t;

   // Operand a always covers lower slot indices than b; invalid nodes never win.
   function automatic node_t pick_min(input node_t a, input node_t b);
      if (!b.valid) return a;
      if (!a.valid) return b;
      if (a.rank < b.rank || (a.rank == b.rank && MIN_TIE_OLDEST)) return a;
      return b;
   endfunction

   function automatic node_t pick_max(input node_t a, input node_t b);
      if (!a.valid) return b;
      if (!b.valid) return a;
      if (b.rank > a.rank || (b.rank == a.rank && MAX_TIE_NEWEST)) return b;
      return a;
   endfunction

   function automatic sel_t select(input logic [DEPTH-1:0]                 v,
                                   input logic [DEPTH-1:0][RANK_WIDTH-1:0] r);
      node_t mn [NODES];
      node_t mx [NODES];
      sel_t  res;
      for (int k = 0; k < LEAVES; k++) begin
         mn[LEAVES-1+k] = '0;
         if (k < DEPTH) begin
            mn[LEAVES-1+k].valid = v[k];
            mn[LEAVES-1+k].rank  = r[k];
            mn[LEAVES-1+k].idx   = IDX_W'(k);
         end
         mx[LEAVES-1+k] = mn[LEAVES-1+k];
      end
      for (int n = LEAVES - 2; n >= 0; n--) begin
         mn[n] = pick_min(mn[2*n+1], mn[2*n+2]);
         mx[n] = pick_max(mx[2*n+1], mx[2*n+2]);
      end
      res.min_idx = mn[0].idx;
      res.max_idx = mx[0].idx;
      return res;
   endfunction

   sel_t sel;

   assign sel       = select(valid_i, rank_i);
   assign min_idx_o = sel.min_idx;
   assign max_idx_o = sel.max_idx;

endmodule

// File: rtl/pifo_reg_hs.sv
// Push-in-first-out register with valid/ready handshakes: presents the
// minimum-rank entry, evicts the worst entry on overflow.
module pifo_reg_hs
   import pifo_pkg::*;
#(
   parameter int DEPTH      = 8,
   parameter int RANK_WIDTH = 16,
   parameter int META_WIDTH = 32,
   parameter int CNT_WIDTH  = clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [RANK_WIDTH-1:0] in_rank,
   input  logic [META_WIDTH-1:0] in_meta,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [RANK_WIDTH-1:0] out_rank,
   output logic [META_WIDTH-1:0] out_meta,
   output logic                  drop_valid,
   output logic [RANK_WIDTH-1:0] drop_rank,
   output logic [META_WIDTH-1:0] drop_meta,
   output logic [CNT_WIDTH-1:0]  num_entries,
   output logic                  empty,
   output logic                  full
);

   localparam int                   IDX_W    = clog2(DEPTH);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

   typedef struct packed {
      logic                  valid;
      logic [RANK_WIDTH-1:0] rank;
      logic [META_WIDTH-1:0] meta;
   } entry_t;

   entry_t                           slot_q [DEPTH];
   entry_t                           slot_d [DEPTH];
   entry_t                           in_entry;
   logic [CNT_WIDTH-1:0]             num_q, num_d;
   logic                             drop_valid_q, drop_valid_d;
   logic [RANK_WIDTH-1:0]            drop_rank_q, drop_rank_d;
   logic [META_WIDTH-1:0]            drop_meta_q, drop_meta_d;
   logic [DEPTH-1:0]                 valid_vec;
   logic [DEPTH-1:0][RANK_WIDTH-1:0] rank_vec;
   logic [IDX_W-1:0]                 min_idx, max_idx;
   logic                             is_empty, is_full, do_pop;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         valid_vec[i] = slot_q[i].valid;
         rank_vec[i]  = slot_q[i].rank;
      end
   end

   pifo_sel_tree #(
      .DEPTH      (DEPTH),
      .RANK_WIDTH (RANK_WIDTH),
      .IDX_W      (IDX_W)
   ) u_sel (
      .valid_i   (valid_vec),
      .rank_i    (rank_vec),
      .min_idx_o (min_idx),
      .max_idx_o (max_idx)
   );

   assign is_empty = (num_q == '0);
   assign is_full  = (num_q == CNT_FULL);
   assign do_pop   = out_ready && !is_empty;
   assign in_entry = '{valid: 1'b1, rank: in_rank, meta: in_meta};

   always_comb begin
      // NOTE: every combinational output gets a default first, so no branch can infer a latch.
      slot_d       = slot_q;
      num_d        = num_q;
      drop_valid_d = 1'b0;
      drop_rank_d  = drop_rank_q;
      drop_meta_d  = drop_meta_q;
      if (flush) begin
         for (int i = 0; i < DEPTH; i++) slot_d[i].valid = 1'b0;
         num_d = '0;
      end else if (do_pop) begin
         // Close the gap left by the head; a same-cycle insert refills the top slot.
         for (int i = 0; i < DEPTH - 1; i++)
            if (IDX_W'(i) >= min_idx) slot_d[i] = slot_q[i+1];
         slot_d[DEPTH-1].valid = 1'b0;
         if (in_valid) begin
            for (int i = 0; i < DEPTH; i++)
               if (CNT_WIDTH'(i) == num_q - CNT_ONE) slot_d[i] = in_entry;
         end else begin
            num_d = num_q - CNT_ONE;
         end
      end else if (in_valid) begin
         if (!is_full) begin
            for (int i = 0; i < DEPTH; i++)
               if (CNT_WIDTH'(i) == num_q) slot_d[i] = in_entry;
            num_d = num_q + CNT_ONE;
         end else if (in_rank < slot_q[max_idx].rank) begin
            drop_valid_d = 1'b1;
            drop_rank_d  = slot_q[max_idx].rank;
            drop_meta_d  = slot_q[max_idx].meta;
            for (int i = 0; i < DEPTH - 1; i++)
               if (IDX_W'(i) >= max_idx) slot_d[i] = slot_q[i+1];
            slot_d[DEPTH-1] = in_entry;
         end else begin
            drop_valid_d = 1'b1;
            drop_rank_d  = in_rank;
            drop_meta_d  = in_meta;
         end
      end
   end

   // NOTE: registered state uses non-blocking assignments so all flops update together.
   // NOTE: only valid bits and counters are reset; payloads are gated by valid and need none.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) slot_q[i].valid <= 1'b0;
         num_q        <= '0;
         drop_valid_q <= 1'b0;
      end else begin
         slot_q       <= slot_d;
         num_q        <= num_d;
         drop_valid_q <= drop_valid_d;
         drop_rank_q  <= drop_rank_d;
         drop_meta_q  <= drop_meta_d;
      end
   end

   assign in_ready    = !rst;
   assign out_valid   = !is_empty;
   assign out_rank    = slot_q[min_idx].rank;
   assign out_meta    = slot_q[min_idx].meta;
   assign drop_valid  = drop_valid_q;
   assign drop_rank   = drop_rank_q;
   assign drop_meta   = drop_meta_q;
   assign num_entries = num_q;
   assign empty       = is_empty;
   assign full        = is_full;

endmodule

// File: tb/tb_pifo_reg_hs.sv
// Scoreboard bench for pifo_reg_hs at DEPTH=4: directed stimulus queues the
// expected pops and drops, a negedge monitor compares them as the DUT presents them.
module tb_pifo_reg_hs;

   localparam int DEPTH = 4;
   localparam int RW    = 16;
   localparam int MW    = 32;
   localparam int CW    = 3;

   typedef struct {
      logic [RW-1:0] r;
      logic [MW-1:0] m;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst, flush, in_valid, in_ready, out_valid, out_ready;
   logic [RW-1:0] in_rank, out_rank, drop_rank;
   logic [MW-1:0] in_meta, out_meta, drop_meta;
   logic          drop_valid, empty, full;
   logic [CW-1:0] num_entries;

   exp_t exp_pop[$];
   exp_t exp_drop[$];
   exp_t mon_e, drop_e;
   int   vectors    = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pifo_reg_hs #(
      .DEPTH      (DEPTH),
      .RANK_WIDTH (RW),
      .META_WIDTH (MW),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_rank     (in_rank),
      .in_meta     (in_meta),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_rank    (out_rank),
      .out_meta    (out_meta),
      .drop_valid  (drop_valid),
      .drop_rank   (drop_rank),
      .drop_meta   (drop_meta),
      .num_entries (num_entries),
      .empty       (empty),
      .full        (full)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic insert(input logic [RW-1:0] r, input logic [MW-1:0] m);
      in_valid = 1'b1;
      in_rank  = r;
      in_meta  = m;
      step();
      in_valid = 1'b0;
   endtask

   task automatic expect_pop(input logic [RW-1:0] r, input logic [MW-1:0] m);
      exp_pop.push_back('{r: r, m: m});
   endtask

   task automatic pop_n(input int n);
      out_ready = 1'b1;
      repeat (n) step();
      out_ready = 1'b0;
   endtask

   // Loads {5,3,7,9} with meta = base + rank.
   task automatic fill4(input logic [MW-1:0] base);
      insert(16'd5, base + 32'd5);
      insert(16'd3, base + 32'd3);
      insert(16'd7, base + 32'd7);
      insert(16'd9, base + 32'd9);
   endtask

   // Monitor: a pop happens at the next posedge whenever out_valid && out_ready now.
   always @(negedge clk) begin
      if (!rst && !flush && out_valid && out_ready) begin
         if (exp_pop.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pop: got rank %0d, expected no pop", out_rank);
         end else begin
            mon_e = exp_pop.pop_front();
            check("pop_rank", 64'(out_rank), 64'(mon_e.r));
            check("pop_meta", 64'(out_meta), 64'(mon_e.m));
         end
      end
      if (!rst && drop_valid) begin
         if (exp_drop.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_drop: got rank %0d, expected no drop", drop_rank);
         end else begin
            drop_e = exp_drop.pop_front();
            check("drop_rank", 64'(drop_rank), 64'(drop_e.r));
            check("drop_meta", 64'(drop_meta), 64'(drop_e.m));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_rank   = '0;
      in_meta   = '0;
      repeat (2) step();
      check("in_ready_in_rst", 64'(in_ready), 64'd0);
      rst = 1'b0;
      #1;
      check("rst_empty",      64'(empty),       64'd1);
      check("rst_out_valid",  64'(out_valid),   64'd0);
      check("rst_num",        64'(num_entries), 64'd0);
      check("rst_full",       64'(full),        64'd0);
      check("rst_drop_valid", 64'(drop_valid),  64'd0);
      check("in_ready_after", 64'(in_ready),    64'd1);
      repeat (2) step();
      check("idle_empty", 64'(empty), 64'd1);

      // FIFO tie-break: 5/A, 3/B, 3/C, 9/D pop as B, C, A, D.
      insert(16'd5, 32'hA);
      check("ins1_num",   64'(num_entries), 64'd1);
      check("ins1_valid", 64'(out_valid),   64'd1);
      check("ins1_head",  64'(out_rank),    64'd5);
      insert(16'd3, 32'hB);
      insert(16'd3, 32'hC);
      insert(16'd9, 32'hD);
      check("ins4_full", 64'(full),        64'd1);
      check("ins4_num",  64'(num_entries), 64'd4);
      check("ins4_head", 64'(out_meta),    64'hB);
      expect_pop(16'd3, 32'hB);
      expect_pop(16'd3, 32'hC);
      expect_pop(16'd5, 32'hA);
      expect_pop(16'd9, 32'hD);
      pop_n(4);
      check("t1_empty",     64'(empty),     64'd1);
      check("t1_out_valid", 64'(out_valid), 64'd0);

      // Pop requested while empty is ignored.
      pop_n(2);
      check("empty_pop_num", 64'(num_entries), 64'd0);

      // Overflow with a better rank evicts the stored maximum.
      fill4(32'h200);
      exp_drop.push_back('{r: 16'd9, m: 32'h209});
      insert(16'd4, 32'h204);
      check("t2_drop_pulse", 64'(drop_valid),  64'd1);
      check("t2_num",        64'(num_entries), 64'd4);
      check("t2_full",       64'(full),        64'd1);
      step();
      check("t2_drop_once",  64'(drop_valid),  64'd0);
      expect_pop(16'd3, 32'h203);
      expect_pop(16'd4, 32'h204);
      expect_pop(16'd5, 32'h205);
      expect_pop(16'd7, 32'h207);
      pop_n(4);
      check("t2_empty", 64'(empty), 64'd1);

      // Overflow with an equal-to-max rank drops the incoming entry.
      fill4(32'h300);
      exp_drop.push_back('{r: 16'd9, m: 32'h399});
      insert(16'd9, 32'h399);
      check("t3_drop_pulse", 64'(drop_valid), 64'd1);
      step();
      check("t3_drop_once", 64'(drop_valid), 64'd0);
      check("t3_drop_hold", 64'(drop_meta),  64'h399);
      expect_pop(16'd3, 32'h303);
      expect_pop(16'd5, 32'h305);
      expect_pop(16'd7, 32'h307);
      expect_pop(16'd9, 32'h309);
      pop_n(4);
      check("t3_empty", 64'(empty), 64'd1);

      // Insert and pop on a full queue: head leaves, new entry lands, no drop.
      fill4(32'h400);
      expect_pop(16'd3, 32'h403);
      in_valid  = 1'b1;
      in_rank   = 16'd1;
      in_meta   = 32'h401;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t4_full",       64'(full),        64'd1);
      check("t4_num",        64'(num_entries), 64'd4);
      check("t4_no_drop",    64'(drop_valid),  64'd0);
      check("t4_next_head",  64'(out_rank),    64'd1);
      expect_pop(16'd1, 32'h401);
      expect_pop(16'd5, 32'h405);
      expect_pop(16'd7, 32'h407);
      expect_pop(16'd9, 32'h409);
      pop_n(4);
      check("t4_empty", 64'(empty), 64'd1);

      // Flush beats a concurrent insert.
      insert(16'd8, 32'h508);
      insert(16'd6, 32'h506);
      check("t5_num2", 64'(num_entries), 64'd2);
      in_valid = 1'b1;
      in_rank  = 16'd2;
      in_meta  = 32'h502;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("t5_empty",     64'(empty),       64'd1);
      check("t5_num",       64'(num_entries), 64'd0);
      check("t5_out_valid", 64'(out_valid),   64'd0);
      check("t5_no_drop",   64'(drop_valid),  64'd0);

      step();
      check("pop_queue_drained",  64'(exp_pop.size()),  64'd0);
      check("drop_queue_drained", 64'(exp_drop.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
